// File: rtl/chunk_add_pkg.sv
// Shared definitions for the chunked adder sequencer: FSM state encoding,
// default widths and helpers deriving the chunk count and counter width.
package chunk_add_pkg;

   localparam int DEF_DATA_W  = 12;
   localparam int DEF_CHUNK_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of chunks the operands are split into.
   function automatic int calc_nchunk(input int data_w, input int chunk_w);
      return data_w / chunk_w;
   endfunction

   // Width of the chunk index counter; never narrower than one bit.
   function automatic int calc_cnt_w(input int data_w, input int chunk_w);
      int n;
      n = $clog2(data_w / chunk_w);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/chunked_add_sequencer_if.sv
// Operand/result handshake bundle for chunked_add_sequencer.
// Handshake rule for both channels: a transfer happens on the rising edge
// where valid and ready are both high; valid may not depend on ready.
// The sub signal exists only when CHUNK_ADD_SUB_EN is defined.
interface chunked_add_sequencer_if #(
   parameter int DATA_W = chunk_add_pkg::DEF_DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
`ifdef CHUNK_ADD_SUB_EN
   logic              sub;
`endif
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] sum;
   logic              carry_out;
   logic              busy;

`ifdef CHUNK_ADD_SUB_EN
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, busy
   );
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, busy
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, carry_out, busy
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, carry_out, busy
   );
`endif

endinterface

// File: rtl/chunk_adder.sv
// Purely combinational CHUNK_W-bit ripple-carry adder built from a chain
// of full adders; the sequencer time-shares one instance across chunks.
module chunk_adder
   import chunk_add_pkg::*;
#(
   parameter int CHUNK_W = DEF_CHUNK_W
) (
   input  logic [CHUNK_W-1:0] x,
   input  logic [CHUNK_W-1:0] y,
   input  logic               cin,
   output logic [CHUNK_W-1:0] s,
   output logic               cout
);

   logic c;

   // Ripple the carry through one full adder per bit, LSB first.
   always_comb begin
      s = '0;
      c = cin;
      for (int i = 0; i < CHUNK_W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle adder: adds two DATA_W-bit operands one CHUNK_W-bit chunk per
// cycle through a single shared ripple adder, carrying between chunks in a
// register. Optional subtract mode is enabled by defining CHUNK_ADD_SUB_EN.
module chunked_add_sequencer
   import chunk_add_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CHUNK_W = DEF_CHUNK_W
) (
   input  logic                    clk,
   input  logic                    rst,
   chunked_add_sequencer_if.slave  bus,
   output state_e                  state_dbg
);

   localparam int NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
   localparam int CNT_W  = calc_cnt_w(DATA_W, CHUNK_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

   if (DATA_W % CHUNK_W != 0) begin : g_bad_width
      $error("DATA_W must be an integer multiple of CHUNK_W");
   end
   if (NCHUNK < 2) begin : g_bad_nchunk
      $error("DATA_W/CHUNK_W must be at least 2");
   end

   state_e              state;
   state_e              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic                carry_q;
   logic [DATA_W-1:0]   sum_q;
   logic                cout_q;

   logic [DATA_W-1:0]   b_in;
   logic                cin_init;
   logic [CHUNK_W-1:0]  a_chunk;
   logic [CHUNK_W-1:0]  b_chunk;
   logic [CHUNK_W-1:0]  s_chunk;
   logic                c_chunk;

`ifdef CHUNK_ADD_SUB_EN
   // Subtraction as a + ~b + 1: invert b at acceptance and seed the carry.
   assign b_in     = bus.sub ? ~bus.b : bus.b;
   assign cin_init = bus.sub;
`else
   assign b_in     = bus.b;
   assign cin_init = 1'b0;
`endif

   assign a_chunk = a_q[int'(cnt)*CHUNK_W +: CHUNK_W];
   assign b_chunk = b_q[int'(cnt)*CHUNK_W +: CHUNK_W];

   chunk_adder #(.CHUNK_W(CHUNK_W)) u_chunk_adder (
      .x    (a_chunk),
      .y    (b_chunk),
      .cin  (carry_q),
      .s    (s_chunk),
      .cout (c_chunk)
   );

   // State register; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: accept in IDLE, step through chunks in RUN, retire in DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)    state_nxt = RUN;
         RUN:     if (cnt == LAST)     state_nxt = DONE;
         DONE:    if (bus.out_ready)   state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the current state.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE:    bus.in_ready  = 1'b1;
         RUN:     bus.busy      = 1'b1;
         DONE: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
         end
         default: bus.in_ready  = 1'b0;
      endcase
   end

   // Datapath: latch operands on accept, then write one chunk per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.a;
                  b_q     <= b_in;
                  carry_q <= cin_init;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  cnt     <= '0;
               end
            end
            RUN: begin
               sum_q[int'(cnt)*CHUNK_W +: CHUNK_W] <= s_chunk;
               carry_q <= c_chunk;
               if (cnt == LAST) begin
                  cout_q <= c_chunk;
                  cnt    <= '0;
               end else begin
                  cnt    <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sum       = sum_q;
   assign bus.carry_out = cout_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed bench for chunked_add_sequencer (DATA_W=12, CHUNK_W=3, NCHUNK=4).
// Subtract vectors are included when CHUNK_ADD_SUB_EN is defined.
module tb_chunked_add_sequencer;
   import chunk_add_pkg::*;

   logic   clk;
   logic   rst;
   state_e state_dbg;
   int     vectors;
   int     miscompares;

   chunked_add_sequencer_if #(.DATA_W(12)) bus ();

   chunked_add_sequencer #(.DATA_W(12), .CHUNK_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Driver: present operands and return 1 ns after the accepting edge.
   task automatic send(input logic [11:0] op_a, input logic [11:0] op_b, input logic op_sub);
      int n;
      bus.a = op_a;
      bus.b = op_b;
`ifdef CHUNK_ADD_SUB_EN
      bus.sub = op_sub;
`else
      if (op_sub) $display("note: subtract requested in add-only build");
`endif
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++;
         $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
`ifdef CHUNK_ADD_SUB_EN
      bus.sub = 1'b0;
`endif
   endtask

   // Driver: count edges from the accepting edge until out_valid is seen.
   task automatic wait_valid(output int edges);
      edges = 0;
      while (bus.out_valid !== 1'b1 && edges < 50) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      vectors += 6;
      if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE); end
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      if (bus.sum !== 12'h000) begin miscompares++; $display("FAIL reset_sum: got %h required 000", bus.sum); end
      if (bus.carry_out !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b required 0", bus.carry_out); end
   endtask

   task automatic test_basic();
      int e;
      bus.out_ready = 1'b1;
      send(12'h123, 12'h456, 1'b0);
      vectors += 2;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b required 1", bus.busy); end
      if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_run: got %b required 0", bus.in_ready); end
      wait_valid(e);
      vectors += 3;
      if (e + 1 != 5) begin miscompares++; $display("FAIL basic_latency: got %0d cycles required 5", e + 1); end
      if (bus.sum !== 12'h579) begin miscompares++; $display("FAIL basic_sum: got %h required 579", bus.sum); end
      if (bus.carry_out !== 1'b0) begin miscompares++; $display("FAIL basic_carry: got %b required 0", bus.carry_out); end
      @(posedge clk); #1;
      vectors += 2;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_width: got %b required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready_after: got %b required 1", bus.in_ready); end
   endtask

   task automatic test_carry_chain();
      int e;
      bus.out_ready = 1'b1;
      send(12'hFFF, 12'h001, 1'b0);
      wait_valid(e);
      vectors += 3;
      if (e + 1 != 5) begin miscompares++; $display("FAIL carry_latency: got %0d cycles required 5", e + 1); end
      if (bus.sum !== 12'h000) begin miscompares++; $display("FAIL carry_sum: got %h required 000", bus.sum); end
      if (bus.carry_out !== 1'b1) begin miscompares++; $display("FAIL carry_cout: got %b required 1", bus.carry_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int e;
      bus.out_ready = 1'b0;
      send(12'h800, 12'h800, 1'b0);
      wait_valid(e);
      vectors++;
      if (e + 1 != 5) begin miscompares++; $display("FAIL hold_latency: got %0d cycles required 5", e + 1); end
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = i[0] ? 1'b0 : 1'b1;
         bus.a = 12'h111 + 12'(i);
         bus.b = 12'h222;
         vectors += 4;
         if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b required 1", i, bus.out_valid); end
         if (bus.sum !== 12'h000) begin miscompares++; $display("FAIL hold_sum[%0d]: got %h required 000", i, bus.sum); end
         if (bus.carry_out !== 1'b1) begin miscompares++; $display("FAIL hold_carry[%0d]: got %b required 1", i, bus.carry_out); end
         if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, bus.in_ready); end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid_end: got %b required 1", bus.out_valid); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      vectors += 3;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_retire: got %b required 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_in_ready_after: got %b required 1", bus.in_ready); end
      if (state_dbg !== IDLE) begin miscompares++; $display("FAIL hold_state_after: got %0d required %0d", state_dbg, IDLE); end
      @(posedge clk); #1;
      vectors += 2;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL hold_ignored_busy: got %b required 0", bus.busy); end
      if (bus.sum !== 12'h000) begin miscompares++; $display("FAIL hold_ignored_sum: got %h required 000", bus.sum); end
   endtask

   task automatic test_abort();
      int seen;
      bus.out_ready = 1'b1;
      send(12'h0AB, 12'h0CD, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors += 6;
      if (state_dbg !== IDLE) begin miscompares++; $display("FAIL abort_state: got %0d required %0d", state_dbg, IDLE); end
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b required 0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
      if (bus.sum !== 12'h000) begin miscompares++; $display("FAIL abort_sum: got %h required 000", bus.sum); end
      if (bus.carry_out !== 1'b0) begin miscompares++; $display("FAIL abort_carry: got %b required 0", bus.carry_out); end
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_ready: got %b required 1", bus.in_ready); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen != 0) begin miscompares++; $display("FAIL abort_ghost_result: got %0d valid cycles required 0", seen); end
   endtask

`ifdef CHUNK_ADD_SUB_EN
   task automatic test_sub();
      int e;
      bus.out_ready = 1'b1;
      send(12'h005, 12'h007, 1'b1);
      wait_valid(e);
      vectors += 2;
      if (bus.sum !== 12'hFFE) begin miscompares++; $display("FAIL sub_borrow_sum: got %h required ffe", bus.sum); end
      if (bus.carry_out !== 1'b0) begin miscompares++; $display("FAIL sub_borrow_carry: got %b required 0", bus.carry_out); end
      @(posedge clk); #1;
      send(12'h007, 12'h005, 1'b1);
      wait_valid(e);
      vectors += 2;
      if (bus.sum !== 12'h002) begin miscompares++; $display("FAIL sub_noborrow_sum: got %h required 002", bus.sum); end
      if (bus.carry_out !== 1'b1) begin miscompares++; $display("FAIL sub_noborrow_carry: got %b required 1", bus.carry_out); end
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_back_to_back();
      logic [12:0] exp_q[$];
      logic [12:0] exp;
      logic [11:0] ra;
      logic [11:0] rb;
      logic        acc;
      int          sent;
      int          got;
      int          t;
      int          last_acc;
      bus.out_ready = 1'b1;
      ra = 12'($urandom_range(0, 4095));
      rb = 12'($urandom_range(0, 4095));
      bus.a = ra;
      bus.b = rb;
      bus.in_valid = 1'b1;
      sent = 0;
      got = 0;
      t = 0;
      last_acc = -1;
      while (got < 100 && t < 2000) begin
         acc = bus.in_valid & bus.in_ready;
         if (bus.out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_unexpected: got sum=%h carry=%b required no result", bus.sum, bus.carry_out);
            end else begin
               exp = exp_q.pop_front();
               if ({bus.carry_out, bus.sum} !== exp) begin
                  miscompares++;
                  $display("FAIL b2b_result[%0d]: got carry=%b sum=%h required carry=%b sum=%h",
                           got, bus.carry_out, bus.sum, exp[12], exp[11:0]);
               end
            end
            got++;
         end
         @(posedge clk); #1;
         t++;
         if (acc) begin
            exp_q.push_back({1'b0, ra} + {1'b0, rb});
            sent++;
            if (last_acc >= 0) begin
               vectors++;
               if (t - last_acc != 6) begin
                  miscompares++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles required 6", sent, t - last_acc);
               end
            end
            last_acc = t;
            if (sent == 100) begin
               bus.in_valid = 1'b0;
            end else begin
               ra = 12'($urandom_range(0, 4095));
               rb = 12'($urandom_range(0, 4095));
               bus.a = ra;
               bus.b = rb;
            end
         end
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (got != 100) begin miscompares++; $display("FAIL b2b_count: got %0d results required 100", got); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
`ifdef CHUNK_ADD_SUB_EN
      bus.sub = 1'b0;
`endif
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_carry_chain();
      test_hold();
      test_abort();
`ifdef CHUNK_ADD_SUB_EN
      test_sub();
`endif
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
